// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: data and address widths,
// data-memory depth and the controller state encoding.
package load_store_unit_pkg;

  localparam int LSU_DATA_W    = 16;
  localparam int LSU_ADDR_W    = 6;
  localparam int LSU_MEM_DEPTH = 64;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } lsu_state_t;

endpackage

// File: rtl/load_store_unit_agen.sv
// Address generation for the load/store unit.
// Computes ea = base + sign-extended word offset (modulo 2^DATA_W) and flags
// any address that lands outside the data memory.
// Ports:
//   base    - base register value
//   off     - signed two's-complement word offset
//   ea_word - low ADDR_W bits of the effective address (memory word address)
//   fault   - effective address is beyond the last memory word
module lsu_agen
  import load_store_unit_pkg::*;
#(
  parameter int DATA_W = LSU_DATA_W,
  parameter int ADDR_W = LSU_ADDR_W
) (
  input  logic [DATA_W-1:0] base,
  input  logic [ADDR_W-1:0] off,
  output logic [ADDR_W-1:0] ea_word,
  output logic              fault
);

  localparam logic [DATA_W-1:0] MEM_LIMIT = DATA_W'(LSU_MEM_DEPTH);

  logic [DATA_W-1:0] ea;

  always_comb begin
    ea      = base + {{(DATA_W-ADDR_W){off[ADDR_W-1]}}, off};
    ea_word = ea[ADDR_W-1:0];
    // Any address at or above the memory depth is out of range; this also
    // catches negative-offset wrap (e.g. 0x0000 - 1 = 0xFFFF).
    fault   = (ea >= MEM_LIMIT);
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit in front of a word-addressed data
// memory with a one-cycle registered read port.
// Ports:
//   clk, rst                         - clock, synchronous active-high reset
//   req_valid/req_ready/req_we       - request handshake and direction
//   req_base/req_off/req_wdata       - address operands and store data
//   resp_valid/resp_ready            - response handshake
//   resp_rdata/resp_fault            - load data and out-of-range flag
//   mem_wr_en/mem_rd_en/mem_addr/mem_wdata/mem_rdata - data-memory port
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | ready for a request
// S_ACCESS | one-cycle memory access (write or read enable)
// S_WAIT   | read data returning from memory, captured this cycle
// S_RESP   | response presented until the consumer takes it
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int DATA_W = LSU_DATA_W,
  parameter int ADDR_W = LSU_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [DATA_W-1:0] req_base,
  input  logic [ADDR_W-1:0] req_off,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_fault,
  output logic              mem_wr_en,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  lsu_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              we_q;
  logic              fault_q;
  logic [ADDR_W-1:0] ea_word;
  logic              ea_fault;
  logic              accept;

  lsu_agen #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_agen (
    .base    (req_base),
    .off     (req_off),
    .ea_word (ea_word),
    .fault   (ea_fault)
  );

  assign accept = req_valid && (state_q == S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (req_valid) state_d = ea_fault ? S_RESP : S_ACCESS;
      S_ACCESS: state_d = we_q ? S_RESP : S_WAIT;
      S_WAIT:   state_d = S_RESP;
      S_RESP:   if (resp_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_wr_en  = 1'b0;
    mem_rd_en  = 1'b0;
    case (state_q)
      S_IDLE:   req_ready  = 1'b1;
      S_ACCESS: begin
        mem_wr_en = we_q;
        mem_rd_en = !we_q;
      end
      S_RESP:   resp_valid = 1'b1;
      default:  ;
    endcase
  end

  // Request registers; rdata is cleared on acceptance so stores and faults
  // respond with zero data.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      fault_q <= 1'b0;
    end else if (accept) begin
      addr_q  <= ea_word;
      wdata_q <= req_wdata;
      rdata_q <= '0;
      we_q    <= req_we;
      fault_q <= ea_fault;
    end else if (state_q == S_WAIT) begin
      rdata_q <= mem_rdata;
    end
  end

  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign resp_rdata = rdata_q;
  assign resp_fault = fault_q;

endmodule
